// File: rtl/primitives_pkg.sv
// rtl/primitives_pkg.sv - shared face/vertex types for the raster pipeline
package primitives_pkg;
  localparam int COLOR_W = 24;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Vertex_t;

  typedef struct packed {
    Vertex_t              v1;
    Vertex_t              v2;
    Vertex_t              v3;
    logic [COLOR_W-1:0]   color;
  } Face_t;
endpackage

// File: rtl/face_rasterizer.sv
// rtl/face_rasterizer.sv - bbox scan with incremental edge functions; RAST_SCREEN_CLIP_EN clamps the bbox to the screen
module face_rasterizer
  import primitives_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        screen_width,
  input  logic [15:0]        screen_height,
  input  Face_t              face_i,
  input  logic               face_valid,
  output logic               face_ready,
  output logic [15:0]        pix_x,
  output logic [15:0]        pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               face_done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic [2:0][15:0]    r_vx, r_vy;
  logic [COLOR_W-1:0]  r_color;
  logic [15:0]         r_xmin, r_xmax, r_ymax, r_cx, r_cy;
  logic                r_area_neg;
  logic signed [35:0]  r_row_e [3];
  logic signed [35:0]  r_cur_e [3];

  logic signed [16:0]  w_dx [3];
  logic signed [16:0]  w_dy [3];
  logic signed [35:0]  w_e0 [3];
  logic [2:0]          w_ge, w_le;
  logic signed [35:0]  w_area;
  logic [15:0]         w_xmin, w_xmax, w_ymin, w_ymax, w_xmax_b, w_ymax_b;
  logic                w_degen, w_inside, w_adv, w_last_x, w_last_y;
  logic                w_load, w_step_x, w_step_y;
  logic                w_unused;

  function automatic logic signed [35:0] f_edge(input logic signed [16:0] dx, input logic signed [16:0] dy,
                                                input logic [15:0] ax, input logic [15:0] ay,
                                                input logic [15:0] px, input logic [15:0] py);
    logic signed [16:0] qx, qy;
    logic signed [33:0] p0, p1;
    qx = $signed({1'b0, px}) - $signed({1'b0, ax});
    qy = $signed({1'b0, py}) - $signed({1'b0, ay});
    p0 = 34'(dx) * 34'(qy);
    p1 = 34'(dy) * 34'(qx);
    return 36'(p0) - 36'(p1);
  endfunction

  always_comb begin
    w_xmin = r_vx[0];
    w_xmax = r_vx[0];
    w_ymin = r_vy[0];
    w_ymax = r_vy[0];
    if (r_vx[1] < w_xmin) w_xmin = r_vx[1];
    if (r_vx[2] < w_xmin) w_xmin = r_vx[2];
    if (r_vx[1] > w_xmax) w_xmax = r_vx[1];
    if (r_vx[2] > w_xmax) w_xmax = r_vx[2];
    if (r_vy[1] < w_ymin) w_ymin = r_vy[1];
    if (r_vy[2] < w_ymin) w_ymin = r_vy[2];
    if (r_vy[1] > w_ymax) w_ymax = r_vy[1];
    if (r_vy[2] > w_ymax) w_ymax = r_vy[2];
    w_area = f_edge(w_dx[0], w_dy[0], r_vx[0], r_vy[0], r_vx[2], r_vy[2]);
`ifdef RAST_SCREEN_CLIP_EN
    w_xmax_b = (w_xmax >= screen_width)  ? screen_width  - 16'd1 : w_xmax;
    w_ymax_b = (w_ymax >= screen_height) ? screen_height - 16'd1 : w_ymax;
    // A bbox lying wholly past the screen edge clamps to an empty range.
    w_degen  = (w_area == 36'sd0) || (screen_width == 16'd0) || (screen_height == 16'd0) ||
               (w_xmin > w_xmax_b) || (w_ymin > w_ymax_b);
`else
    w_xmax_b = w_xmax;
    w_ymax_b = w_ymax;
    w_degen  = (w_area == 36'sd0);
`endif
  end

`ifdef RAST_SCREEN_CLIP_EN
  assign w_unused = ^{face_i.v1.z, face_i.v2.z, face_i.v3.z};
`else
  assign w_unused = ^{face_i.v1.z, face_i.v2.z, face_i.v3.z, screen_width, screen_height};
`endif

  assign w_inside   = r_area_neg ? (&w_le) : (&w_ge);
  assign w_adv      = (r_state == S_SCAN) && (!w_inside || pix_ready);
  assign w_last_x   = (r_cx == r_xmax);
  assign w_last_y   = (r_cy == r_ymax);
  assign w_load     = (r_state == S_SETUP);
  assign w_step_x   = w_adv && !w_last_x;
  assign w_step_y   = w_adv && w_last_x && !w_last_y;

  assign face_ready = (r_state == S_IDLE);
  assign face_done  = (r_state == S_DONE);
  assign pix_valid  = (r_state == S_SCAN) && w_inside;
  assign pix_x      = r_cx;
  assign pix_y      = r_cy;
  assign pix_color  = r_color;

  // Edge g runs from vertex g to vertex g+1 (wrapping), i.e. v1->v2, v2->v3, v3->v1.
  for (genvar g = 0; g < 3; g++) begin : g_edge
    localparam int B = (g + 1) % 3;
    assign w_dx[g] = $signed({1'b0, r_vx[B]}) - $signed({1'b0, r_vx[g]});
    assign w_dy[g] = $signed({1'b0, r_vy[B]}) - $signed({1'b0, r_vy[g]});
    assign w_e0[g] = f_edge(w_dx[g], w_dy[g], r_vx[g], r_vy[g], w_xmin, w_ymin);
    assign w_ge[g] = !r_cur_e[g][35];
    assign w_le[g] = r_cur_e[g][35] || (r_cur_e[g] == 36'sd0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_row_e[g] <= '0;
        r_cur_e[g] <= '0;
      end else if (w_load) begin
        r_row_e[g] <= w_e0[g];
        r_cur_e[g] <= w_e0[g];
      end else if (w_step_x) begin
        r_cur_e[g] <= r_cur_e[g] - 36'(w_dy[g]);
      end else if (w_step_y) begin
        r_row_e[g] <= r_row_e[g] + 36'(w_dx[g]);
        r_cur_e[g] <= r_row_e[g] + 36'(w_dx[g]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_vx       <= '0;
      r_vy       <= '0;
      r_color    <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_area_neg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (face_valid) begin
          r_vx    <= {face_i.v3.x, face_i.v2.x, face_i.v1.x};
          r_vy    <= {face_i.v3.y, face_i.v2.y, face_i.v1.y};
          r_color <= face_i.color;
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          r_xmin     <= w_xmin;
          r_xmax     <= w_xmax_b;
          r_ymax     <= w_ymax_b;
          r_cx       <= w_xmin;
          r_cy       <= w_ymin;
          r_area_neg <= w_area[35];
          r_state    <= w_degen ? S_DONE : S_SCAN;
        end
        S_SCAN: if (w_adv) begin
          if (!w_last_x) begin
            r_cx <= r_cx + 16'd1;
          end else if (!w_last_y) begin
            r_cx <= r_xmin;
            r_cy <= r_cy + 16'd1;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_face_rasterizer.sv
// tb/tb_face_rasterizer.sv - directed scoreboard bench for face_rasterizer
module tb_face_rasterizer;
  import primitives_pkg::*;

  typedef struct packed {
    logic [15:0]        x;
    logic [15:0]        y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [15:0]        screen_width = 16'd640;
  logic [15:0]        screen_height = 16'd480;
  Face_t              face = '0;
  logic               face_valid = 1'b0;
  logic               face_ready;
  logic [15:0]        pix_x, pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_valid;
  logic               pix_ready = 1'b1;
  logic               face_done;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   t0 = 0, first_pix = -1, done_at = -1, ready_at = -1;
  int   npix = 0, ndone = 0, max_x = -1;
  bit   tog_mode = 1'b0;
  bit   prev_stall = 1'b0;
  pix_t prev_pix = '0;
  pix_t exp_q[$];

  face_rasterizer dut (
    .clk(clk), .rst_n(rst_n), .screen_width(screen_width), .screen_height(screen_height),
    .face_i(face), .face_valid(face_valid), .face_ready(face_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .face_done(face_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ef(longint ax, longint ay, longint bx, longint by, longint px, longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  task automatic push_expected(input int x1, input int y1, input int x2, input int y2,
                               input int x3, input int y3, input logic [COLOR_W-1:0] col);
    longint a, e0, e1, e2;
    int xmin, xmax, ymin, ymax;
    pix_t p;
    a = ef(x1, y1, x2, y2, x3, y3);
    xmin = (x1 < x2) ? ((x1 < x3) ? x1 : x3) : ((x2 < x3) ? x2 : x3);
    xmax = (x1 > x2) ? ((x1 > x3) ? x1 : x3) : ((x2 > x3) ? x2 : x3);
    ymin = (y1 < y2) ? ((y1 < y3) ? y1 : y3) : ((y2 < y3) ? y2 : y3);
    ymax = (y1 > y2) ? ((y1 > y3) ? y1 : y3) : ((y2 > y3) ? y2 : y3);
`ifdef RAST_SCREEN_CLIP_EN
    if (xmax > int'(screen_width) - 1) xmax = int'(screen_width) - 1;
    if (ymax > int'(screen_height) - 1) ymax = int'(screen_height) - 1;
`endif
    if (a == 0) return;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        e0 = ef(x1, y1, x2, y2, x, y);
        e1 = ef(x2, y2, x3, y3, x, y);
        e2 = ef(x3, y3, x1, y1, x, y);
        if ((a > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) || (a < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          p.x = 16'(x);
          p.y = 16'(y);
          p.c = col;
          exp_q.push_back(p);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    pix_ready = tog_mode ? !pix_ready : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (face_valid && face_ready) t0 = cyc;
      if (face_done) begin
        ndone++;
        done_at = cyc - t0;
      end
      if (face_ready && ndone > 0 && ready_at < 0) ready_at = cyc - t0;
      if (prev_stall) begin
        check("stall_valid", pix_valid, 1);
        check("stall_x", pix_x, prev_pix.x);
        check("stall_y", pix_y, prev_pix.y);
        check("stall_color", pix_color, prev_pix.c);
      end
      if (pix_valid) begin
        if (first_pix < 0) first_pix = cyc - t0;
        if (pix_ready) begin
          check("pixel_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            pix_t e;
            e = exp_q.pop_front();
            check("pix_x", pix_x, e.x);
            check("pix_y", pix_y, e.y);
            check("pix_color", pix_color, e.c);
          end
          npix++;
          if (int'(pix_x) > max_x) max_x = int'(pix_x);
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = '{pix_x, pix_y, pix_color};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_monitor();
    npix = 0; ndone = 0; first_pix = -1; done_at = -1; ready_at = -1; max_x = -1;
  endtask

  task automatic start_face(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3, input logic [COLOR_W-1:0] col);
    @(posedge clk);
    #1;
    face = '0;
    face.v1.x = 16'(x1); face.v1.y = 16'(y1);
    face.v2.x = 16'(x2); face.v2.y = 16'(y2);
    face.v3.x = 16'(x3); face.v3.y = 16'(y3);
    face.color = col;
    face_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (face_ready) break;
    end
    @(posedge clk);
    #1;
    face_valid = 1'b0;
  endtask

  task automatic run_face(input string tag, input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3, input logic [COLOR_W-1:0] col, input bit tog,
                          input int exp_n, input int exp_first, input int exp_done);
    clear_monitor();
    push_expected(x1, y1, x2, y2, x3, y3, col);
    tog_mode = tog;
    start_face(x1, y1, x2, y2, x3, y3, col);
    for (int i = 0; i < 3000; i++) begin
      if (ndone > 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    tog_mode = 1'b0;
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_pixels"}, npix, exp_n);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    if (exp_first >= 0) check({tag, "_first_pix_cycle"}, first_pix, exp_first);
    if (exp_done >= 0) begin
      check({tag, "_done_cycle"}, done_at, exp_done);
      check({tag, "_ready_cycle"}, ready_at, exp_done + 1);
    end
    exp_q.delete();
  endtask

  initial begin
    #12;
    check("reset_face_ready", face_ready, 1);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_face_done", face_done, 0);
    check("reset_pix_x", pix_x, 0);
    check("reset_pix_y", pix_y, 0);
    check("reset_pix_color", pix_color, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_face("tri_ccw", 0, 0, 4, 0, 0, 4, 24'hA1B2C3, 1'b0, 15, 2, 27);
    run_face("tri_cw", 0, 0, 0, 4, 4, 0, 24'h123456, 1'b0, 15, 2, 27);
    run_face("degenerate", 1, 1, 2, 2, 3, 3, 24'h00FF00, 1'b0, 0, -1, 2);
    check("degenerate_no_pixel", first_pix, -1);
    run_face("toggle", 0, 0, 4, 0, 0, 4, 24'h0F0F0F, 1'b1, 15, 2, -1);

    run_face("edge", 638, 0, 640, 0, 640, 2, 24'hCAFE01, 1'b0,
`ifdef RAST_SCREEN_CLIP_EN
             3,
`else
             6,
`endif
             -1, -1);
`ifdef RAST_SCREEN_CLIP_EN
    check("edge_max_x", max_x, 639);
`else
    check("edge_max_x", max_x, 640);
`endif

    clear_monitor();
    push_expected(0, 0, 4, 0, 0, 4, 24'h777777);
    start_face(0, 0, 4, 0, 0, 4, 24'h777777);
    repeat (2) @(negedge clk);
    check("pre_reset_valid", pix_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pix_valid", pix_valid, 0);
    check("async_reset_face_ready", face_ready, 1);
    check("async_reset_face_done", face_done, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("reset_no_face_done", ndone, 0);
    run_face("after_reset", 0, 0, 4, 0, 0, 4, 24'h314159, 1'b0, 15, 2, 27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
